// File: rtl/alu_mult_sequencer_pkg.sv
// Shared ALU opcode constants and the multiply sequencer state encoding.
// Contents:
//   OP_ADD .. OP_SRA        5-bit opcodes understood by the shared ALU
//   ST_IDLE/ST_RUN/ST_DONE  2-bit sequencer state encoding
package alu_ops_pkg;

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_AND = 5'b00010;
    localparam logic [4:0] OP_OR  = 5'b00011;
    localparam logic [4:0] OP_SLL = 5'b00100;
    localparam logic [4:0] OP_SRA = 5'b00101;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/alu_mult_sequencer_if.sv
// Bundle between the multiply sequencer, the execute stage and the shared ALU.
// Signals:
//   ctrl_MULT, data_operandA/B          start request and operands (to sequencer)
//   in_ready, data_result,
//   data_exception, data_resultRDY      handshake and result (from sequencer)
//   alu_req, alu_operandA/B,
//   alu_opcode, alu_shiftamt            ALU request and operation (from sequencer)
//   alu_gnt, alu_result, alu_overflow   ALU grant and response (to sequencer)
// Modports: slave = the sequencer, master = its environment.
interface alu_mult_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             ctrl_MULT;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             in_ready;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             alu_req;
    logic             alu_gnt;
    logic [WIDTH-1:0] alu_operandA;
    logic [WIDTH-1:0] alu_operandB;
    logic [4:0]       alu_opcode;
    logic [4:0]       alu_shiftamt;
    logic [WIDTH-1:0] alu_result;
    logic             alu_overflow;

    modport slave (
        input  ctrl_MULT, data_operandA, data_operandB, alu_gnt, alu_result, alu_overflow,
        output in_ready, data_result, data_exception, data_resultRDY,
               alu_req, alu_operandA, alu_operandB, alu_opcode, alu_shiftamt
    );

    modport master (
        output ctrl_MULT, data_operandA, data_operandB, alu_gnt, alu_result, alu_overflow,
        input  in_ready, data_result, data_exception, data_resultRDY,
               alu_req, alu_operandA, alu_operandB, alu_opcode, alu_shiftamt
    );
endinterface

// File: rtl/alu_mult_sequencer_booth_step.sv
// One radix-2 Booth iteration, purely combinational.
// Ports:
//   pair_i          {Q[0], q_1}
//   a_i, q_i        current accumulator and multiplier
//   alu_result_i    A +/- M from the shared ALU
//   alu_overflow_i  ALU overflow for that op
//   needs_alu_o     this step uses the ALU (pair 01 or 10)
//   opcode_o        OP_ADD for 01, OP_SUB for 10
//   a_o, q_o, q1_o  state after the arithmetic shift right
module booth_step
    import alu_ops_pkg::*;
#(
    parameter int         WIDTH  = 32,
    parameter logic [4:0] OP_ADD = alu_ops_pkg::OP_ADD,
    parameter logic [4:0] OP_SUB = alu_ops_pkg::OP_SUB
) (
    input  logic [1:0]       pair_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] alu_result_i,
    input  logic             alu_overflow_i,
    output logic             needs_alu_o,
    output logic [4:0]       opcode_o,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] q_o,
    output logic             q1_o
);
    logic [WIDTH-1:0] sum;
    logic             sgn;

    always_comb begin
        needs_alu_o = (pair_i == 2'b01) || (pair_i == 2'b10);
        opcode_o    = (pair_i == 2'b10) ? OP_SUB : OP_ADD;
        sum         = needs_alu_o ? alu_result_i : a_i;
        // A +/- M can need 33 bits; overflow flips the visible sign bit back
        // to the true sign, which is what the shift must replicate.
        sgn         = needs_alu_o ? (alu_result_i[WIDTH-1] ^ alu_overflow_i) : a_i[WIDTH-1];
        a_o         = {sgn, sum[WIDTH-1:1]};
        q_o         = {sum[0], q_i[WIDTH-1:1]};
        q1_o        = q_i[0];
    end
endmodule

// File: rtl/alu_mult_sequencer.sv
// Multi-cycle signed multiply controller (radix-2 Booth) that borrows the
// shared ALU for its add/subtract steps through an alu_req/alu_gnt pair.
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous, active-low
//   bus    alu_mult_sequencer_if.slave: start/operands/result handshake and
//          the ALU request/response signals
module alu_mult_sequencer
    import alu_ops_pkg::*;
#(
    parameter int         WIDTH  = 32,
    parameter logic [4:0] OP_ADD = alu_ops_pkg::OP_ADD,
    parameter logic [4:0] OP_SUB = alu_ops_pkg::OP_SUB
) (
    input  logic                   clock,
    input  logic                   reset,
    alu_mult_sequencer_if.slave    bus
);
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, q_q, q_d, m_q, m_d;
    logic             q1_q, q1_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             exc_q, exc_d;

    logic             needs_alu;
    logic [4:0]       step_op;
    logic [WIDTH-1:0] a_nx, q_nx;
    logic             q1_nx;
    logic             run, req, step_done;
    logic [WIDTH:0]   top_bits;

    booth_step #(
        .WIDTH  (WIDTH),
        .OP_ADD (OP_ADD),
        .OP_SUB (OP_SUB)
    ) u_step (
        .pair_i         ({q_q[0], q1_q}),
        .a_i            (a_q),
        .q_i            (q_q),
        .alu_result_i   (bus.alu_result),
        .alu_overflow_i (bus.alu_overflow),
        .needs_alu_o    (needs_alu),
        .opcode_o       (step_op),
        .a_o            (a_nx),
        .q_o            (q_nx),
        .q1_o           (q1_nx)
    );

    assign run       = (state_q == ST_RUN);
    assign req       = run && needs_alu;
    // Steps without ALU use always complete; ALU steps wait for the grant.
    assign step_done = run && (!needs_alu || bus.alu_gnt);
    assign top_bits  = {a_nx, q_nx[WIDTH-1]};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        q1_d    = q1_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        exc_d   = exc_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.ctrl_MULT) begin
                    m_d     = bus.data_operandA;
                    q_d     = bus.data_operandB;
                    a_d     = '0;
                    q1_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (step_done) begin
                    a_d   = a_nx;
                    q_d   = q_nx;
                    q1_d  = q1_nx;
                    cnt_d = cnt_q + 1'b1;
                    // Result is captured on the final step so it is already
                    // valid during the single DONE cycle.
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        res_d   = q_nx;
                        exc_d   = ~((&top_bits) | ~(|top_bits));
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            q1_q    <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            q1_q    <= q1_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            exc_q   <= exc_d;
        end
    end

    assign bus.in_ready       = (state_q == ST_IDLE);
    assign bus.data_resultRDY = (state_q == ST_DONE);
    assign bus.data_result    = res_q;
    assign bus.data_exception = exc_q;
    assign bus.alu_req        = req;
    assign bus.alu_operandA   = req ? a_q : '0;
    assign bus.alu_operandB   = req ? m_q : '0;
    assign bus.alu_opcode     = req ? step_op : OP_ADD;
    assign bus.alu_shiftamt   = '0;
endmodule

// File: tb/tb_alu_mult_sequencer.sv
module tb_alu_mult_sequencer;
    import alu_ops_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    alu_mult_sequencer_if #(.WIDTH(32)) bus ();

    alu_mult_sequencer #(
        .WIDTH  (32),
        .OP_ADD (OP_ADD),
        .OP_SUB (OP_SUB)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural shared ALU: add/sub with signed overflow.
    logic [31:0] alu_sum, alu_dif;
    assign alu_sum = bus.alu_operandA + bus.alu_operandB;
    assign alu_dif = bus.alu_operandA - bus.alu_operandB;
    assign bus.alu_result   = (bus.alu_opcode == OP_SUB) ? alu_dif : alu_sum;
    assign bus.alu_overflow = (bus.alu_opcode == OP_SUB)
        ? ((bus.alu_operandA[31] != bus.alu_operandB[31]) && (alu_dif[31] != bus.alu_operandA[31]))
        : ((bus.alu_operandA[31] == bus.alu_operandB[31]) && (alu_sum[31] != bus.alu_operandA[31]));

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Result monitor: every resultRDY pulse must match the oldest pending op.
    always @(negedge clock) begin
        if (reset && bus.data_resultRDY) begin
            check("rdy_pending", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("result",    64'(bus.data_result),    64'(e.res));
                check("exception", 64'(bus.data_exception), 64'(e.exc));
                check("latency",   64'(cyc - e.acc),        64'(e.lat));
            end
        end
    end

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input int stalls);
        longint p;
        exp_t   e;
        for (int i = 0; i < 100 && !bus.in_ready; i++) @(negedge clock);
        check("in_ready_wait", 64'(bus.in_ready), 64'd1);
        p     = longint'($signed(a)) * longint'($signed(b));
        e.res = p[31:0];
        e.exc = (p != longint'($signed(p[31:0])));
        e.lat = 32 + stalls;
        e.acc = cyc + 1;
        sb.push_back(e);
        bus.data_operandA = a;
        bus.data_operandB = b;
        bus.ctrl_MULT     = 1'b1;
        @(negedge clock);
        bus.ctrl_MULT     = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clock);
        #1;
        check("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.ctrl_MULT     = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        bus.alu_gnt       = 1'b1;   // granted while idle: must be ignored
        repeat (3) @(negedge clock);

        check("rst_in_ready",  64'(bus.in_ready),       64'd1);
        check("rst_rdy",       64'(bus.data_resultRDY), 64'd0);
        check("rst_result",    64'(bus.data_result),    64'd0);
        check("rst_exception", 64'(bus.data_exception), 64'd0);
        check("rst_alu_req",   64'(bus.alu_req),        64'd0);
        check("rst_opcode",    64'(bus.alu_opcode),     64'(OP_ADD));
        check("rst_opA",       64'(bus.alu_operandA),   64'd0);
        reset = 1'b1;
        @(negedge clock);
        check("idle_alu_req",  64'(bus.alu_req),        64'd0);

        // Directed products
        start_op(32'd3, 32'd4, 0);
        check("shiftamt", 64'(bus.alu_shiftamt), 64'd0);
        drain();
        start_op(-32'sd7, 32'd6, 0);
        start_op(32'h0001_0000, 32'h0001_0000, 0);
        start_op(32'h8000_0000, 32'hFFFF_FFFF, 0);
        start_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 0);
        drain();

        // Grant withheld for 10 cycles while every step needs the ALU
        start_op(32'd5, 32'h5555_5555, 10);
        repeat (5) @(negedge clock);
        bus.alu_gnt = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("stall_req",      64'(bus.alu_req),  64'd1);
            check("stall_in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.alu_gnt = 1'b1;
        drain();

        // Start request during RUN is ignored
        start_op(32'd123, -32'sd456, 0);
        repeat (8) @(negedge clock);
        bus.data_operandA = 32'd999;
        bus.data_operandB = 32'd999;
        bus.ctrl_MULT     = 1'b1;
        check("run_in_ready", 64'(bus.in_ready), 64'd0);
        @(negedge clock);
        bus.ctrl_MULT = 1'b0;
        drain();
        repeat (40) @(negedge clock);

        // Reset mid-RUN aborts the op without a result pulse
        start_op(32'd77, 32'd99, 0);
        repeat (14) @(negedge clock);
        reset = 1'b0;
        sb.delete();
        #1;
        check("abort_in_ready", 64'(bus.in_ready),       64'd1);
        check("abort_rdy",      64'(bus.data_resultRDY), 64'd0);
        check("abort_result",   64'(bus.data_result),    64'd0);
        check("abort_alu_req",  64'(bus.alu_req),        64'd0);
        @(negedge clock);
        reset = 1'b1;
        repeat (40) @(negedge clock);
        start_op(-32'sd1000, 32'd2000, 0);
        drain();

        // A few random operand pairs
        for (int i = 0; i < 4; i++) begin
            start_op($urandom, $urandom, 0);
            drain();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
